// File: rtl/chan_scan_ctrl.sv
// Channel scan sequencer: walks cur_idx across pc[] and stops at the first set channel.
// Optional `SCAN_WRAP_EN: a miss on the last channel wraps back to channel 0 instead of finishing.
module chan_scan_ctrl #(
   parameter int NUM_CH = 17,
   parameter int IDX_W  = 5,
   parameter int DWELL  = 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic              enable,
   input  logic              abort,
   input  logic [NUM_CH-1:0] pc,
   output logic              busy,
   output logic              done,
   output logic              hit,
   output logic [IDX_W-1:0]  hit_idx,
   output logic [IDX_W-1:0]  cur_idx
);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

   localparam logic [3:0]       DW_LAST  = 4'(DWELL - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

   state_t           r_state;
   logic [3:0]       r_dwell;
   logic             r_busy;
   logic             r_done;
   logic             r_hit;
   logic [IDX_W-1:0] r_hit_idx;
   logic [IDX_W-1:0] r_cur_idx;
   logic             w_pc_bit;

   assign w_pc_bit = pc[r_cur_idx];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_dwell   <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_hit     <= 1'b0;
         r_hit_idx <= '0;
         r_cur_idx <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state   <= S_SCAN;
                  r_busy    <= 1'b1;
                  r_dwell   <= '0;
                  r_cur_idx <= '0;
                  r_hit     <= 1'b0;
                  r_hit_idx <= '0;
               end
            end
            S_SCAN: begin
               // abort outranks a sample landing on the same edge
               if (abort) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else if (enable) begin
                  if (r_dwell != DW_LAST) begin
                     r_dwell <= r_dwell + 4'd1;
                  end else if (w_pc_bit) begin
                     r_hit     <= 1'b1;
                     r_hit_idx <= r_cur_idx;
                     r_state   <= S_DONE;
                     r_done    <= 1'b1;
                  end else if (r_cur_idx == LAST_IDX) begin
`ifdef SCAN_WRAP_EN
                     r_cur_idx <= '0;
                     r_dwell   <= '0;
`else
                     r_state   <= S_DONE;
                     r_done    <= 1'b1;
`endif
                  end else begin
                     r_cur_idx <= r_cur_idx + 1'b1;
                     r_dwell   <= '0;
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign hit     = r_hit;
   assign hit_idx = r_hit_idx;
   assign cur_idx = r_cur_idx;

endmodule

// File: tb/tb_chan_scan_ctrl.sv
// Scoreboard bench for chan_scan_ctrl: one instance with DWELL=1 and one with DWELL=3.
// Expected completions are queued at start and checked when done rises.
module tb_chan_scan_ctrl;

   typedef struct {
      int   t0;
      int   lat;
      logic hit;
      int   idx;
      int   cidx;
   } exp_t;

   logic        clock;
   logic        reset_n;
   logic        start1, start3;
   logic        enable;
   logic        abort;
   logic [16:0] pc;
   logic        busy1, done1, hit1;
   logic [4:0]  hit_idx1, cur_idx1;
   logic        busy3, done3, hit3;
   logic [4:0]  hit_idx3, cur_idx3;

   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   exp_t q1[$];
   exp_t q3[$];

   chan_scan_ctrl #(.NUM_CH(17), .IDX_W(5), .DWELL(1)) u_dut1 (
      .clock(clock), .reset_n(reset_n), .start(start1), .enable(enable), .abort(abort),
      .pc(pc), .busy(busy1), .done(done1), .hit(hit1), .hit_idx(hit_idx1), .cur_idx(cur_idx1)
   );

   chan_scan_ctrl #(.NUM_CH(17), .IDX_W(5), .DWELL(3)) u_dut3 (
      .clock(clock), .reset_n(reset_n), .start(start3), .enable(enable), .abort(abort),
      .pc(pc), .busy(busy3), .done(done3), .hit(hit3), .hit_idx(hit_idx3), .cur_idx(cur_idx3)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   always @(negedge clock) begin
      if (reset_n === 1'b1 && done1 === 1'b1) begin
         if (q1.size() == 0) chk("d1_unexpected_done", 1, 0);
         else begin
            exp_t e;
            e = q1.pop_front();
            chk("d1_latency", cyc - e.t0, e.lat);
            chk("d1_hit", hit1, e.hit);
            chk("d1_hit_idx", hit_idx1, e.idx);
            chk("d1_cur_idx", cur_idx1, e.cidx);
            chk("d1_busy_in_done", busy1, 1);
         end
      end
   end

   always @(negedge clock) begin
      if (reset_n === 1'b1 && done3 === 1'b1) begin
         if (q3.size() == 0) chk("d3_unexpected_done", 1, 0);
         else begin
            exp_t e;
            e = q3.pop_front();
            chk("d3_latency", cyc - e.t0, e.lat);
            chk("d3_hit", hit3, e.hit);
            chk("d3_hit_idx", hit_idx3, e.idx);
            chk("d3_cur_idx", cur_idx3, e.cidx);
            chk("d3_busy_in_done", busy3, 1);
         end
      end
   end

   // Drives a one-edge start; t0 is the cycle count just after the accepting edge.
   task automatic do_start(input int which, input logic [16:0] p, input logic with_abort, output int t0);
      pc     = p;
      abort  = with_abort;
      start1 = (which == 1);
      start3 = (which == 3);
      @(posedge clock); #1;
      t0     = cyc;
      start1 = 1'b0;
      start3 = 1'b0;
      abort  = 1'b0;
   endtask

   task automatic push(input int which, input int t0, input int lat, input logic h, input int idx, input int cidx);
      exp_t e;
      e.t0 = t0; e.lat = lat; e.hit = h; e.idx = idx; e.cidx = cidx;
      if (which == 1) q1.push_back(e);
      else q3.push_back(e);
   endtask

   task automatic wait_idle(input int which, input int max);
      int n;
      n = 0;
      while (n < max) begin
         @(posedge clock); #1;
         n++;
         if (which == 1 && q1.size() == 0 && !busy1) break;
         if (which == 3 && q3.size() == 0 && !busy3) break;
      end
      if (n >= max) chk("idle_timeout", 0, 1);
   endtask

   task automatic wait_cur(input int which, input int val, input int max);
      int n;
      n = 0;
      while (n < max) begin
         if (which == 1 && int'(cur_idx1) == val) break;
         if (which == 3 && int'(cur_idx3) == val) break;
         @(posedge clock); #1;
         n++;
      end
      if (n >= max) chk("cur_idx_timeout", 0, 1);
   endtask

   initial begin
      int t0;
      int lat;
      reset_n = 1'b0;
      start1  = 1'b0;
      start3  = 1'b0;
      enable  = 1'b0;
      abort   = 1'b0;
      pc      = '0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_busy", busy1, 0);
      chk("rst_done", done1, 0);
      chk("rst_hit", hit1, 0);
      chk("rst_hit_idx", hit_idx1, 0);
      chk("rst_cur_idx", cur_idx1, 0);
      chk("rst_busy3", busy3, 0);
      reset_n = 1'b1;
      enable  = 1'b1;
      @(posedge clock); #1;

      // first hit: bits 5 and 8 set, channel 5 wins
      do_start(1, 17'h00120, 1'b0, t0);
      push(1, t0, 6, 1'b1, 5, 5);
      wait_idle(1, 40);
      chk("hold_hit", hit1, 1);
      chk("hold_hit_idx", hit_idx1, 5);
      chk("idle_done", done1, 0);

      // start and abort together in IDLE: start is accepted
      do_start(1, 17'h00120, 1'b1, t0);
      push(1, t0, 6, 1'b1, 5, 5);
      wait_idle(1, 40);

      do_start(1, 17'h00001, 1'b0, t0);
      push(1, t0, 1, 1'b1, 0, 0);
      wait_idle(1, 40);

      do_start(1, 17'h10000, 1'b0, t0);
      push(1, t0, 17, 1'b1, 16, 16);
      wait_idle(1, 60);

`ifndef SCAN_WRAP_EN
      do_start(1, 17'h00000, 1'b0, t0);
      push(1, t0, 17, 1'b0, 0, 16);
      wait_idle(1, 60);
      chk("miss_hit_held", hit1, 0);
`endif

      // dwell of 3, ungated then with enable low for 4 cycles on channel 1
      do_start(3, 17'h00004, 1'b0, t0);
      push(3, t0, 9, 1'b1, 2, 2);
      wait_idle(3, 60);

      do_start(3, 17'h00004, 1'b0, t0);
      push(3, t0, 13, 1'b1, 2, 2);
      wait_cur(3, 1, 20);
      enable = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      enable = 1'b1;
      wait_idle(3, 60);

      // leave hit=1 so the abort run shows start clearing it
      do_start(1, 17'h1FFFF, 1'b0, t0);
      push(1, t0, 1, 1'b1, 0, 0);
      wait_idle(1, 40);

      do_start(1, 17'h00008, 1'b0, t0);
      start1 = 1'b1;
      @(posedge clock); #1;
      start1 = 1'b0;
      wait_cur(1, 3, 20);
      abort = 1'b1;
      @(posedge clock); #1;
      abort = 1'b0;
      chk("abort_busy", busy1, 0);
      chk("abort_hit", hit1, 0);
      chk("abort_hit_idx", hit_idx1, 0);
      repeat (25) @(posedge clock);
      #1;
      chk("abort_stays_idle", busy1, 0);

      // asynchronous reset in the middle of a scan
      do_start(1, 17'h00000, 1'b0, t0);
      wait_cur(1, 7, 20);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy1, 0);
      chk("mid_rst_done", done1, 0);
      chk("mid_rst_cur_idx", cur_idx1, 0);
      chk("mid_rst_hit", hit1, 0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      repeat (25) @(posedge clock);
      #1;
      chk("post_rst_busy", busy1, 0);

`ifdef SCAN_WRAP_EN
      do_start(1, 17'h00000, 1'b0, t0);
      lat = 3;
      while (lat <= 40) lat += 17;
      push(1, t0, lat, 1'b1, 2, 2);
      repeat (17) @(posedge clock);
      #1;
      chk("wrap_cur_idx", cur_idx1, 0);
      chk("wrap_busy", busy1, 1);
      repeat (23) @(posedge clock);
      #1;
      pc = 17'h00004;
      wait_idle(1, 60);
`else
      lat = 0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
